// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer: buffers operand pairs, runs one sequential multiply at a time, returns products in order.
// The watchdog aborts a job that sees no mul_done within TIMEOUT cycles of LAUNCH.
module mult_job_sequencer #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [WIDTH-1:0]             i_in_multiplier,
  input  logic [WIDTH-1:0]             i_in_multiplicand,
  output logic                         o_mul_start,
  output logic [WIDTH-1:0]             o_mul_multiplier,
  output logic [WIDTH-1:0]             o_mul_multiplicand,
  input  logic [2*WIDTH-1:0]           i_mul_product,
  input  logic                         i_mul_done,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [2*WIDTH-1:0]           o_out_product,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_busy,
  output logic                         o_err_timeout
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
  state_t               r_state;
  logic [2*WIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]        r_wr, r_rd;
  logic [CW-1:0]        r_count;
  logic [TW-1:0]        r_wd;
  logic                 r_start, r_out_valid, r_err;
  logic [WIDTH-1:0]     r_a, r_b;
  logic [2*WIDTH-1:0]   r_prod;
  logic                 w_push, w_pop;
  assign o_in_ready         = r_count != CW'(DEPTH);
  assign w_push             = i_in_valid && o_in_ready;
  assign w_pop              = r_state == IDLE && r_count != '0;
  assign o_mul_start        = r_start;
  assign o_mul_multiplier   = r_a;
  assign o_mul_multiplicand = r_b;
  assign o_out_valid        = r_out_valid;
  assign o_out_product      = r_prod;
  assign o_count            = r_count;
  assign o_busy             = r_state != IDLE || r_count != '0;
  assign o_err_timeout      = r_err;
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr] <= {i_in_multiplier, i_in_multiplicand};
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= w_push ? r_wr + 1'b1 : r_wr;
      r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  // r_wd counts cycles since entering LAUNCH, so the abort lands TIMEOUT cycles after it.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_start     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_wd        <= '0;
      r_out_valid <= 1'b0;
      r_prod      <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_pop) begin
          {r_a, r_b} <= r_mem[r_rd];
          r_start    <= 1'b1;
          r_state    <= LAUNCH;
        end
        LAUNCH: begin
          r_start <= 1'b0;
          r_wd    <= TW'(1);
          r_state <= WAIT;
        end
        WAIT: if (i_mul_done) begin
          r_prod      <= i_mul_product;
          r_out_valid <= 1'b1;
          r_state     <= HOLD;
        end else if (r_wd == TW'(TIMEOUT - 1)) begin
          r_err   <= 1'b1;
          r_state <= IDLE;
        end else r_wd <= r_wd + 1'b1;
        HOLD: if (i_out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule
